// File: rtl/gpio_bank_ctrl.sv
// Register-controlled GPIO bank: drives pad_io di/oe/ie/pu/pd, synchronises and
// debounces pad dc, and latches per-pin edge events into W1C pending bits.
module gpio_bank_ctrl #(
   parameter int W   = 8,
   parameter int DBW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wr_en,
   input  logic           rd_en,
   input  logic [3:0]     addr,
   input  logic [W-1:0]   wdata,
   output logic [W-1:0]   rdata,
   output logic           irq,
   input  logic [W-1:0]   pad_dc,
   output logic [W-1:0]   pad_di,
   output logic [W-1:0]   pad_oe,
   output logic [W-1:0]   pad_ie,
   output logic [W-1:0]   pad_pu,
   output logic [W-1:0]   pad_pd
);

   typedef enum logic [3:0] {
      REG_OUT     = 4'd0,
      REG_OE      = 4'd1,
      REG_IE      = 4'd2,
      REG_PU      = 4'd3,
      REG_PD      = 4'd4,
      REG_IN      = 4'd5,
      REG_IRQ_EN  = 4'd6,
      REG_RISE_EN = 4'd7,
      REG_FALL_EN = 4'd8,
      REG_PEND    = 4'd9,
      REG_DB      = 4'd10
   } reg_addr_e;

   logic [W-1:0]          r_out, r_oe, r_ie, r_pu, r_pd;
   logic [W-1:0]          r_irq_en, r_rise_en, r_fall_en, r_pend;
   logic [DBW-1:0]        r_db;
   logic [W-1:0]          r_s1, r_s2, r_stable;
   logic [W-1:0][DBW-1:0] r_cnt;
   logic [W-1:0]          r_rdata;

   logic [W-1:0]          w_pend_clr, w_ie_kill, w_rise, w_fall, w_pend_nxt;
   logic [W-1:0]          w_stable_nxt, w_rd_data;
   logic [W-1:0][DBW-1:0] w_cnt_nxt;
   logic [DBW-1:0]        w_db_last;
   logic                  w_db_wr;

   assign w_pend_clr = (wr_en && addr == REG_PEND) ? wdata : '0;
   // Only pins whose IE actually falls are flushed, so an idle pin keeps its history.
   assign w_ie_kill  = (wr_en && addr == REG_IE) ? (r_ie & ~wdata) : '0;
   assign w_db_wr    = wr_en && (addr == REG_DB);
   assign w_db_last  = r_db - DBW'(1);

   always_comb begin
      // NOTE: defaults first so every path assigns every bit and no latch is inferred.
      w_stable_nxt = r_stable;
      w_cnt_nxt    = r_cnt;
      for (int i = 0; i < W; i++) begin
         if (r_s2[i] == r_stable[i]) begin
            w_cnt_nxt[i] = '0;
         end else if (r_db == '0) begin
            w_stable_nxt[i] = r_s2[i];
         end else if (r_cnt[i] == w_db_last) begin
            w_stable_nxt[i] = r_s2[i];
            w_cnt_nxt[i]    = '0;
         end else begin
            w_cnt_nxt[i] = r_cnt[i] + DBW'(1);
         end
         if (w_db_wr) begin
            w_stable_nxt[i] = r_stable[i];
            w_cnt_nxt[i]    = '0;
         end
         if (w_ie_kill[i]) begin
            w_stable_nxt[i] = 1'b0;
            w_cnt_nxt[i]    = '0;
         end
      end
   end

   assign w_rise     = ~r_stable &  w_stable_nxt & r_rise_en & ~w_ie_kill;
   assign w_fall     =  r_stable & ~w_stable_nxt & r_fall_en & ~w_ie_kill;
   // A new event and a W1C hit on the same bit leave it set.
   assign w_pend_nxt = (r_pend & ~w_pend_clr) | w_rise | w_fall;

   always_comb begin
      w_rd_data = '0;
      case (addr)
         REG_OUT:     w_rd_data = r_out;
         REG_OE:      w_rd_data = r_oe;
         REG_IE:      w_rd_data = r_ie;
         REG_PU:      w_rd_data = r_pu;
         REG_PD:      w_rd_data = r_pd;
         REG_IN:      w_rd_data = r_stable;
         REG_IRQ_EN:  w_rd_data = r_irq_en;
         REG_RISE_EN: w_rd_data = r_rise_en;
         REG_FALL_EN: w_rd_data = r_fall_en;
         REG_PEND:    w_rd_data = r_pend;
         REG_DB:      w_rd_data = W'(r_db);
         default:     w_rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         r_out     <= '0;
         r_oe      <= '0;
         r_ie      <= '0;
         r_pu      <= '0;
         r_pd      <= '0;
         r_irq_en  <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
         r_pend    <= '0;
         r_db      <= '0;
         r_s1      <= '0;
         r_s2      <= '0;
         r_stable  <= '0;
         r_cnt     <= '0;
         r_rdata   <= '0;
      end else begin
         if (wr_en) begin
            case (addr)
               REG_OUT:     r_out     <= wdata;
               REG_OE:      r_oe      <= wdata;
               REG_IE:      r_ie      <= wdata;
               REG_PU:      r_pu      <= wdata;
               REG_PD:      r_pd      <= wdata;
               REG_IRQ_EN:  r_irq_en  <= wdata;
               REG_RISE_EN: r_rise_en <= wdata;
               REG_FALL_EN: r_fall_en <= wdata;
               REG_DB:      r_db      <= DBW'(wdata);
               default:     ;
            endcase
         end
         r_s1     <= pad_dc & r_ie & ~w_ie_kill;
         r_s2     <= r_s1 & ~w_ie_kill;
         r_stable <= w_stable_nxt;
         r_cnt    <= w_cnt_nxt;
         r_pend   <= w_pend_nxt;
         if (rd_en) begin
            r_rdata <= w_rd_data;
         end
      end
   end

   assign rdata  = r_rdata;
   assign irq    = |(r_pend & r_irq_en);
   assign pad_di = r_out;
   assign pad_oe = r_oe;
   assign pad_ie = r_ie;
   assign pad_pu = r_pu;
   assign pad_pd = r_pd & ~r_pu;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed bench for gpio_bank_ctrl: a register/pad vector table plus
// hand-written debounce, edge-event, W1C, IE-clear and reset sequences.
module tb_gpio_bank_ctrl;

   logic       clk = 1'b0;
   logic       rst, wr_en, rd_en;
   logic [3:0] addr;
   logic [7:0] wdata, rdata, pad_dc, pad_di, pad_oe, pad_ie, pad_pu, pad_pd;
   logic       irq;

   int n_pass  = 0;
   int n_total = 0;

   gpio_bank_ctrl #(.W(8), .DBW(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .rd_en  (rd_en),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .irq    (irq),
      .pad_dc (pad_dc),
      .pad_di (pad_di),
      .pad_oe (pad_oe),
      .pad_ie (pad_ie),
      .pad_pu (pad_pu),
      .pad_pd (pad_pd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
      logic [7:0] exp_di;
      logic [7:0] exp_oe;
      logic [7:0] exp_pu;
      logic [7:0] exp_pd;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_wr(input logic [3:0] a, input logic [7:0] d);
      addr  = a;
      wdata = d;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic reg_rd(input logic [3:0] a, output logic [7:0] d);
      addr  = a;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      d     = rdata;
   endtask

   task automatic check_all_zero(input string tag);
      logic [7:0] d;
      check({tag, " pad_di"}, pad_di, 8'h00);
      check({tag, " pad_oe"}, pad_oe, 8'h00);
      check({tag, " pad_ie"}, pad_ie, 8'h00);
      check({tag, " pad_pu"}, pad_pu, 8'h00);
      check({tag, " pad_pd"}, pad_pd, 8'h00);
      check({tag, " irq"}, {7'd0, irq}, 8'h00);
      check({tag, " rdata"}, rdata, 8'h00);
      for (int a = 0; a <= 10; a++) begin
         reg_rd(4'(a), d);
         check($sformatf("%s reg%0d", tag, a), d, 8'h00);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;

      vecs[0] = '{4'd0,  8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00};
      vecs[1] = '{4'd1,  8'hFF, 8'hFF, 8'hA5, 8'hFF, 8'h00, 8'h00};
      vecs[2] = '{4'd3,  8'h0F, 8'h0F, 8'hA5, 8'hFF, 8'h0F, 8'h00};
      vecs[3] = '{4'd4,  8'hFF, 8'hFF, 8'hA5, 8'hFF, 8'h0F, 8'hF0};
      vecs[4] = '{4'd5,  8'h3C, 8'h00, 8'hA5, 8'hFF, 8'h0F, 8'hF0};
      vecs[5] = '{4'd11, 8'h77, 8'h00, 8'hA5, 8'hFF, 8'h0F, 8'hF0};
      vecs[6] = '{4'd10, 8'h07, 8'h07, 8'hA5, 8'hFF, 8'h0F, 8'hF0};
      vecs[7] = '{4'd7,  8'h5A, 8'h5A, 8'hA5, 8'hFF, 8'h0F, 8'hF0};
      vecs[8] = '{4'd8,  8'hC3, 8'hC3, 8'hA5, 8'hFF, 8'h0F, 8'hF0};
      vecs[9] = '{4'd6,  8'h00, 8'h00, 8'hA5, 8'hFF, 8'h0F, 8'hF0};

      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; pad_dc = '0;
      tick();
      tick();
      rst = 1'b0;
      check_all_zero("reset");

      // Register map and pad outputs
      for (int i = 0; i < 10; i++) begin
         reg_wr(vecs[i].addr, vecs[i].wdata);
         check($sformatf("vec%0d pad_di", i), pad_di, vecs[i].exp_di);
         check($sformatf("vec%0d pad_oe", i), pad_oe, vecs[i].exp_oe);
         check($sformatf("vec%0d pad_pu", i), pad_pu, vecs[i].exp_pu);
         check($sformatf("vec%0d pad_pd", i), pad_pd, vecs[i].exp_pd);
         reg_rd(vecs[i].addr, d);
         check($sformatf("vec%0d rdata", i), d, vecs[i].exp_rd);
      end

      // Simultaneous read and write of OUT returns the old value
      addr = 4'd0; wdata = 8'h11; wr_en = 1'b1; rd_en = 1'b1;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      check("rd_wr same edge old", rdata, 8'hA5);
      check("rd_wr pad_di new", pad_di, 8'h11);
      reg_rd(4'd0, d);
      check("rd_wr readback new", d, 8'h11);

      // Debounce, T=4: 3-cycle glitch is filtered
      rst = 1'b1; tick(); rst = 1'b0;
      reg_wr(4'd2, 8'h01);
      reg_wr(4'd10, 8'h04);
      reg_wr(4'd7, 8'h01);
      reg_wr(4'd6, 8'h01);
      check("ie pad_ie", pad_ie, 8'h01);
      pad_dc = 8'h01;
      tick(); tick(); tick();
      pad_dc = 8'h00;
      for (int j = 0; j < 6; j++) tick();
      check("glitch irq", {7'd0, irq}, 8'h00);
      reg_rd(4'd5, d);
      check("glitch IN", d, 8'h00);
      reg_rd(4'd9, d);
      check("glitch PEND", d, 8'h00);

      // Debounce, T=4: held high reaches IN and PEND at edge k+5
      pad_dc = 8'h01;
      for (int j = 1; j <= 6; j++) begin
         tick();
         if (j == 5) check("held irq k+4", {7'd0, irq}, 8'h00);
         if (j == 6) check("held irq k+5", {7'd0, irq}, 8'h01);
      end
      reg_rd(4'd5, d);
      check("held IN", d, 8'h01);
      reg_rd(4'd9, d);
      check("held PEND", d, 8'h01);

      // W1C clear alone, then T=0 rising edge at k+2
      reg_wr(4'd9, 8'h01);
      check("w1c irq", {7'd0, irq}, 8'h00);
      reg_wr(4'd10, 8'h00);
      pad_dc = 8'h00;
      for (int j = 0; j < 4; j++) tick();
      check("t0 fall no irq", {7'd0, irq}, 8'h00);
      pad_dc = 8'h01;
      tick();
      tick();
      check("t0 irq k+1", {7'd0, irq}, 8'h00);
      tick();
      check("t0 irq k+2", {7'd0, irq}, 8'h01);
      reg_rd(4'd9, d);
      check("t0 PEND", d, 8'h01);

      // Set and clear on the same edge: set wins
      pad_dc = 8'h00;
      for (int j = 0; j < 4; j++) tick();
      pad_dc = 8'h01;
      tick();
      tick();
      reg_wr(4'd9, 8'h01);
      check("set wins irq", {7'd0, irq}, 8'h01);
      reg_rd(4'd9, d);
      check("set wins PEND", d, 8'h01);

      // IRQ_EN masks irq but keeps PEND
      reg_wr(4'd6, 8'h00);
      check("mask irq", {7'd0, irq}, 8'h00);
      reg_rd(4'd9, d);
      check("mask PEND kept", d, 8'h01);
      reg_wr(4'd6, 8'h01);
      check("unmask irq", {7'd0, irq}, 8'h01);
      reg_wr(4'd9, 8'h01);
      check("clear irq", {7'd0, irq}, 8'h00);
      reg_rd(4'd9, d);
      check("clear PEND", d, 8'h00);

      // Clearing IE flushes the input path without a fall event
      reg_wr(4'd8, 8'h01);
      reg_rd(4'd5, d);
      check("pre ie-clear IN", d, 8'h01);
      reg_wr(4'd2, 8'h00);
      check("ie-clear irq", {7'd0, irq}, 8'h00);
      reg_rd(4'd5, d);
      check("ie-clear IN", d, 8'h00);
      for (int j = 0; j < 3; j++) tick();
      reg_rd(4'd9, d);
      check("ie-clear PEND", d, 8'h00);

      // Reset mid-debounce (T=4, cnt=2)
      reg_wr(4'd2, 8'h01);
      reg_wr(4'd10, 8'h04);
      reg_wr(4'd0, 8'h3C);
      pad_dc = 8'h00;
      for (int j = 0; j < 4; j++) tick();
      pad_dc = 8'h01;
      for (int j = 0; j < 4; j++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pad_dc = 8'h00;
      check_all_zero("midrst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
